wb_alu_master: RTL and testbench



---
 rtl/wb_alu_master.sv | 206 ++++++++++++++++++++
 tb/tb_wb_alu_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_alu_master.sv
// rtl/wb_alu_master.sv - Wishbone pipelined initiator that runs one ALU operation per start pulse
//
// Purpose: on an accepted start, writes operand A (BASE+0), operand B (BASE+12)
// and the opcode (BASE+16) to the ALU peripheral, idles SETTLE_CYCLES cycles,
// then reads the 64-bit result as low word (BASE+8) and high word (BASE+20).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                run request, sampled only while idle
//   i_op_a, i_op_b       32-bit operands, latched on start acceptance
//   i_opcode             4-bit opcode, latched on start acceptance
//   o_busy               run in progress (acceptance up to, not including, done cycle)
//   o_done               one-cycle pulse at the end of every run
//   o_error              last run aborted by timeout, sticky until next accepted start
//   o_result             {high word, low word} of the last successful run
//   o_wb_cyc/stb/we      Wishbone pipelined master controls
//   o_wb_addr/o_wb_data  request address and write data
//   i_wb_ack/stall/data  slave response
//
// Build option: define WB_MASTER_TIMEOUT_EN to enable the per-transfer timeout
// (TIMEOUT_CYCLES); otherwise the master waits indefinitely and o_error is 0.

module wb_alu_master #(
   parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
   parameter int          SETTLE_CYCLES  = 2,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic [3:0]  i_opcode,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [63:0] o_result,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data
);

   localparam logic [31:0] OFF_A  = 32'd0;
   localparam logic [31:0] OFF_B  = 32'd12;
   localparam logic [31:0] OFF_OP = 32'd16;
   localparam logic [31:0] OFF_LO = 32'd8;
   localparam logic [31:0] OFF_HI = 32'd20;
   localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;

   typedef enum logic [3:0] {
      IDLE, WR_A, WR_B, WR_OP, SETTLE, RD_LO, RD_HI, DONE, ERR
   } state_t;

   state_t      state, state_nx;
   logic        waiting, waiting_nx;   // 0: issue phase, 1: wait-for-ack phase
   logic [31:0] op_a, op_b;
   logic [3:0]  opcode;
   logic [31:0] shadow;
   logic [31:0] settle_cnt;
   logic        bus_state, start_ok, issue_ok, xfer_done, timed_out;

   assign bus_state = (state == WR_A) || (state == WR_B) || (state == WR_OP) ||
                      (state == RD_LO) || (state == RD_HI);
   assign start_ok  = (state == IDLE) && start;
   assign issue_ok  = bus_state && !waiting && !i_wb_stall;
   // ack only counts in the wait phase; acks seen while issuing are ignored
   assign xfer_done = bus_state && waiting && i_wb_ack;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   logic [31:0] tmo_cnt;
   logic        error;

   assign timed_out = bus_state && !xfer_done && (tmo_cnt == TIMEOUT_LAST);

   // counter restarts whenever the state changes, so it spans issue + wait of one transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  tmo_cnt <= '0;
      else if (state_nx != state) tmo_cnt <= '0;
      else if (bus_state)         tmo_cnt <= tmo_cnt + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          error <= 1'b0;
      else if (start_ok)  error <= 1'b0;
      else if (timed_out) error <= 1'b1;
   end

   assign o_error = error;
`else
   assign timed_out = 1'b0;
   assign o_error   = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      waiting_nx = waiting;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = WR_A;
               waiting_nx = 1'b0;
            end
         end
         WR_A, WR_B, WR_OP, RD_LO, RD_HI: begin
            if (timed_out) begin
               state_nx   = ERR;
               waiting_nx = 1'b0;
            end else if (issue_ok) begin
               waiting_nx = 1'b1;
            end else if (xfer_done) begin
               waiting_nx = 1'b0;
               case (state)
                  WR_A:    state_nx = WR_B;
                  WR_B:    state_nx = WR_OP;
                  WR_OP:   state_nx = (SETTLE_CYCLES == 0) ? RD_LO : SETTLE;
                  RD_LO:   state_nx = RD_HI;
                  default: state_nx = DONE;
               endcase
            end
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_nx = RD_LO;
         end
         default: state_nx = IDLE;   // DONE and ERR last one cycle
      endcase
   end

   always_comb begin
      o_wb_addr = '0;
      o_wb_we   = 1'b0;
      o_wb_data = '0;
      case (state)
         WR_A: begin
            o_wb_addr = BASE_ADDRESS + OFF_A;
            o_wb_we   = 1'b1;
            o_wb_data = op_a;
         end
         WR_B: begin
            o_wb_addr = BASE_ADDRESS + OFF_B;
            o_wb_we   = 1'b1;
            o_wb_data = op_b;
         end
         WR_OP: begin
            o_wb_addr = BASE_ADDRESS + OFF_OP;
            o_wb_we   = 1'b1;
            o_wb_data = {28'b0, opcode};
         end
         RD_LO:   o_wb_addr = BASE_ADDRESS + OFF_LO;
         RD_HI:   o_wb_addr = BASE_ADDRESS + OFF_HI;
         default: ;
      endcase
   end

   // combinational from the async-reset state so reset drops cyc/stb immediately
   assign o_wb_cyc = bus_state || (state == SETTLE);
   assign o_wb_stb = bus_state && !waiting;
   assign o_busy   = (state != IDLE) && (state != DONE) && (state != ERR);
   assign o_done   = (state == DONE) || (state == ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         waiting <= 1'b0;
      end else begin
         state   <= state_nx;
         waiting <= waiting_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         opcode <= '0;
      end else if (start_ok) begin
         op_a   <= i_op_a;
         op_b   <= i_op_b;
         opcode <= i_opcode;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 settle_cnt <= '0;
      else if (state == SETTLE)  settle_cnt <= settle_cnt + 32'd1;
      else                       settle_cnt <= '0;
   end

   // result is loaded only on the high-word ack, never partially
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow   <= '0;
         o_result <= '0;
      end else if (xfer_done && (state == RD_LO)) begin
         shadow   <= i_wb_data;
      end else if (xfer_done && (state == RD_HI)) begin
         o_result <= {i_wb_data, shadow};
      end
   end

endmodule

// File: tb/tb_wb_alu_master.sv
// tb/tb_wb_alu_master.sv - self-checking bench for wb_alu_master with an ALU slave model

module tb_wb_alu_master;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam int          SETTLE = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] i_op_a, i_op_b;
   logic [3:0]  i_opcode;
   logic        o_busy, o_done, o_error;
   logic [63:0] o_result;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0] o_wb_addr, o_wb_data;
   logic        i_wb_ack = 1'b0;
   logic        i_wb_stall = 1'b0;
   logic [31:0] i_wb_data = 32'h0;

   wb_alu_master #(
      .BASE_ADDRESS(BASE), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .i_op_a(i_op_a), .i_op_b(i_op_b), .i_opcode(i_opcode),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_result(o_result),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int checks = 0;
   int errors = 0;

   // slave model configuration
   int          ack_lat = 1;
   int          stall_left = 0;
   logic [31:0] stall_addr = 32'h0;
   bit          hold_lo = 1'b0;

   logic [64:0] log_q[$];
   logic [64:0] exp_q[$];
   logic [31:0] r_a = 0, r_b = 0;
   logic [3:0]  r_op = 0;
   logic        pend = 1'b0;
   int          t = 0;
   logic [31:0] paddr = 0;
   logic [63:0] last_result = 64'h0;

   int run_cyc_gap, run_stall_bad;
   logic run_err_first;

   function automatic logic [63:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'd5:    return {32'b0, a} + {32'b0, b};
         4'd8:    return {32'b0, a} * {32'b0, b};
         default: return {a ^ b, a - b};
      endcase
   endfunction

   function automatic logic [31:0] read_val(input logic [31:0] ad);
      logic [63:0] res;
      res = alu(r_a, r_b, r_op);
      if (ad == BASE + 32'd8)  return res[31:0];
      if (ad == BASE + 32'd20) return res[63:32];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic bit held(input logic [31:0] ad);
      return hold_lo && (ad == BASE + 32'd8);
   endfunction

   // ALU peripheral: registers written over the bus, result readable after a programmable ack latency
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         i_wb_ack <= 1'b0;
         pend     <= 1'b0;
         t        <= 0;
      end else begin
         i_wb_ack <= 1'b0;
         if (o_wb_stb && !i_wb_stall) begin
            log_q.push_back({o_wb_we, o_wb_addr, o_wb_we ? o_wb_data : 32'h0});
            if (o_wb_we && o_wb_addr == BASE)          r_a  <= o_wb_data;
            if (o_wb_we && o_wb_addr == BASE + 32'd12) r_b  <= o_wb_data;
            if (o_wb_we && o_wb_addr == BASE + 32'd16) r_op <= o_wb_data[3:0];
            if (ack_lat == 1 && !held(o_wb_addr)) begin
               i_wb_ack  <= 1'b1;
               i_wb_data <= read_val(o_wb_addr);
            end else begin
               pend  <= 1'b1;
               paddr <= o_wb_addr;
               t     <= held(o_wb_addr) ? ack_lat : ack_lat - 1;
            end
         end else if (!o_wb_cyc) begin
            pend <= 1'b0;
         end else if (pend && !held(paddr)) begin
            if (t <= 1) begin
               i_wb_ack  <= 1'b1;
               i_wb_data <= read_val(paddr);
               pend      <= 1'b0;
            end else begin
               t <= t - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (o_wb_stb && o_wb_addr == stall_addr && stall_left > 0) begin
         i_wb_stall = 1'b1;
         stall_left = stall_left - 1;
      end else begin
         i_wb_stall = 1'b0;
      end
   end

   task automatic build_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      exp_q.delete();
      exp_q.push_back({1'b1, BASE, a});
      exp_q.push_back({1'b1, BASE + 32'd12, b});
      exp_q.push_back({1'b1, BASE + 32'd16, {28'b0, op}});
      exp_q.push_back({1'b0, BASE + 32'd8, 32'h0});
      exp_q.push_back({1'b0, BASE + 32'd20, 32'h0});
   endtask

   function automatic bit log_matches();
      if (log_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // start one run and wait for o_done; dt is the edge count from acceptance, -1 on no done
   task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input bit inj_en, input logic [31:0] inj_addr, output int dt);
      int e;
      bit injected, drop;
      @(negedge clk);
      i_op_a = a; i_op_b = b; i_opcode = op; start = 1'b1;
      log_q.delete();
      @(posedge clk); #1 e = cycle;
      dt = -1; run_cyc_gap = 0; run_stall_bad = 0; injected = 0; drop = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin start = 1'b0; run_err_first = o_error; end
         if (drop) begin start = 1'b0; drop = 0; end
         if (inj_en && !injected && o_wb_stb && o_wb_addr == inj_addr) begin
            i_op_a = $urandom; i_op_b = $urandom; i_opcode = 4'($urandom);
            start = 1'b1; injected = 1; drop = 1;
         end
         if (i_wb_stall && (!o_wb_stb || o_wb_addr !== stall_addr)) run_stall_bad++;
         if (o_done) begin dt = cycle - e; break; end
         if (!o_wb_cyc) run_cyc_gap++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; i_op_a = 0; i_op_b = 0; i_opcode = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_busy, o_done, o_error, o_wb_cyc, o_wb_stb, o_wb_we} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 000000", {o_busy, o_done, o_error, o_wb_cyc, o_wb_stb, o_wb_we});
      end
      checks++;
      if (o_result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", o_result); end
      checks++;
      if ({o_wb_addr, o_wb_data} !== 64'h0) begin
         errors++; $display("FAIL reset_bus got %h %h want 0 0", o_wb_addr, o_wb_data);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int dt;
      ack_lat = 1; stall_left = 0;
      do_run(32'hFFFF_FFFF, 32'h1, 4'd5, 0, 0, dt);
      build_exp(32'hFFFF_FFFF, 32'h1, 4'd5);
      checks++; if (dt !== 12) begin errors++; $display("FAIL basic_done_time got %0d want 12", dt); end
      checks++; if (o_result !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL basic_result got %h want 0000000100000000", o_result); end
      checks++; if (!log_matches()) begin errors++; $display("FAIL basic_bus_log got %0d entries want 5 matching", log_q.size()); end
      checks++; if (o_busy !== 1'b0 || run_cyc_gap != 0) begin errors++; $display("FAIL basic_busy_cyc got busy %b gaps %0d want 0 0", o_busy, run_cyc_gap); end
      do_run(32'h1234_5678, 32'h0001_0000, 4'd8, 0, 0, dt);
      checks++; if (o_result !== 64'h0000_1234_5678_0000) begin errors++; $display("FAIL mul_result got %h want 0000123456780000", o_result); end
      checks++; if (o_error !== 1'b0 || dt !== 12) begin errors++; $display("FAIL mul_status got err %b dt %0d want 0 12", o_error, dt); end
      last_result = 64'h0000_1234_5678_0000;
   endtask

   task automatic test_stall;
      int dt;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      ack_lat = 1; stall_addr = BASE + 32'd12; stall_left = 3;
      do_run(a, b, 4'd5, 0, 0, dt);
      build_exp(a, b, 4'd5);
      checks++; if (dt !== 15) begin errors++; $display("FAIL stall_done_time got %0d want 15", dt); end
      checks++; if (run_stall_bad != 0 || stall_left != 0) begin errors++; $display("FAIL stall_hold got bad %0d left %0d want 0 0", run_stall_bad, stall_left); end
      checks++; if (o_result !== alu(a, b, 4'd5)) begin errors++; $display("FAIL stall_result got %h want %h", o_result, alu(a, b, 4'd5)); end
      checks++; if (!log_matches()) begin errors++; $display("FAIL stall_bus_log got %0d entries want 5 matching", log_q.size()); end
      last_result = alu(a, b, 4'd5);
   endtask

   task automatic test_repulse;
      int dt;
      logic [31:0] a, b;
      logic [3:0] op;
      a = $urandom; b = $urandom; op = 4'($urandom);
      ack_lat = 1; stall_left = 0;
      do_run(a, b, op, 1, BASE + 32'd12, dt);
      build_exp(a, b, op);
      checks++; if (o_result !== alu(a, b, op)) begin errors++; $display("FAIL repulse_result got %h want %h", o_result, alu(a, b, op)); end
      checks++; if (!log_matches() || dt !== 12) begin errors++; $display("FAIL repulse_bus got %0d entries dt %0d want 5 12", log_q.size(), dt); end
      @(negedge clk); #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL repulse_retrigger got busy %b want 0", o_busy); end
      last_result = alu(a, b, op);
   endtask

   task automatic test_back_to_back;
      int e, d1, d2;
      logic [31:0] a1, b1, a2, b2;
      logic [3:0] o1, o2;
      a1 = $urandom; b1 = $urandom; o1 = 4'($urandom);
      a2 = $urandom; b2 = $urandom; o2 = 4'($urandom);
      ack_lat = 1; stall_left = 0;
      @(negedge clk);
      i_op_a = a1; i_op_b = b1; i_opcode = o1; start = 1'b1;
      @(posedge clk); #1 e = cycle;
      @(negedge clk);
      i_op_a = a2; i_op_b = b2; i_opcode = o2;
      d1 = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (o_done) begin d1 = cycle - e; break; end
      end
      checks++; if (d1 !== 12) begin errors++; $display("FAIL b2b_first_time got %0d want 12", d1); end
      checks++; if (o_result !== alu(a1, b1, o1)) begin errors++; $display("FAIL b2b_first_result got %h want %h", o_result, alu(a1, b1, o1)); end
      @(negedge clk); #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy %b want 0", o_busy); end
      @(negedge clk); #1;
      start = 1'b0;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got busy %b want 1", o_busy); end
      d2 = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (o_done) begin d2 = cycle - e; break; end
      end
      checks++; if (d2 !== 26) begin errors++; $display("FAIL b2b_second_time got %0d want 26", d2); end
      checks++; if (o_result !== alu(a2, b2, o2)) begin errors++; $display("FAIL b2b_second_result got %h want %h", o_result, alu(a2, b2, o2)); end
      last_result = alu(a2, b2, o2);
      repeat (2) @(negedge clk);
   endtask

`ifdef WB_MASTER_TIMEOUT_EN
   task automatic test_timeout;
      int dt;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      ack_lat = 1; stall_left = 0; hold_lo = 1'b1;
      do_run(a, b, 4'd8, 0, 0, dt);
      checks++; if (dt !== 16) begin errors++; $display("FAIL timeout_time got %0d want 16", dt); end
      checks++; if (o_error !== 1'b1 || o_wb_cyc !== 1'b0) begin errors++; $display("FAIL timeout_status got err %b cyc %b want 1 0", o_error, o_wb_cyc); end
      checks++; if (o_result !== last_result) begin errors++; $display("FAIL timeout_result got %h want %h", o_result, last_result); end
      hold_lo = 1'b0;
      @(negedge clk); #1;
      checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", o_error); end
      do_run(b, a, 4'd5, 0, 0, dt);
      checks++; if (run_err_first !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", run_err_first); end
      checks++; if (o_result !== alu(b, a, 4'd5) || dt !== 12) begin errors++; $display("FAIL timeout_recover got %h dt %0d want %h 12", o_result, dt, alu(b, a, 4'd5)); end
      last_result = alu(b, a, 4'd5);
   endtask
`else
   task automatic test_no_timeout;
      int e, dt, bad;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      ack_lat = 1; stall_left = 0; hold_lo = 1'b1; bad = 0;
      @(negedge clk);
      i_op_a = a; i_op_b = b; i_opcode = 4'd5; start = 1'b1;
      @(posedge clk); #1 e = cycle;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (k == 0) start = 1'b0;
         if (o_done || !o_wb_cyc || o_error) bad++;
      end
      hold_lo = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL wait_forever got %0d bad cycles want 0", bad); end
      dt = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (o_done) begin dt = cycle - e; break; end
      end
      checks++; if (dt !== 43) begin errors++; $display("FAIL late_ack_time got %0d want 43", dt); end
      checks++; if (o_result !== alu(a, b, 4'd5) || o_error !== 1'b0) begin errors++; $display("FAIL late_ack_result got %h err %b want %h 0", o_result, o_error, alu(a, b, 4'd5)); end
      last_result = alu(a, b, 4'd5);
   endtask
`endif

   task automatic test_reset_midrun;
      int dt, dones;
      bit found;
      logic [31:0] a, b;
      ack_lat = 2; stall_left = 0; found = 0; dones = 0;
      @(negedge clk);
      i_op_a = $urandom; i_op_b = $urandom; i_opcode = 4'd5; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         start = 1'b0;
         if (o_wb_cyc && !o_wb_stb && o_wb_addr == BASE + 32'd16) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midrun_reach got no WR_OP wait phase want one"); end
      reset = 1'b1;
      #1;
      checks++; if ({o_wb_cyc, o_wb_stb, o_busy} !== 3'b0) begin errors++; $display("FAIL midrun_async got %b want 000", {o_wb_cyc, o_wb_stb, o_busy}); end
      @(negedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         if (o_done || o_busy) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL midrun_no_done got %0d want 0", dones); end
      a = $urandom; b = $urandom; ack_lat = 1;
      do_run(a, b, 4'd8, 0, 0, dt);
      checks++; if (o_result !== alu(a, b, 4'd8) || dt !== 12) begin errors++; $display("FAIL midrun_recover got %h dt %0d want %h 12", o_result, dt, alu(a, b, 4'd8)); end
      last_result = alu(a, b, 4'd8);
   endtask

   task automatic test_random;
      int dt, s, l, exp_dt;
      logic [31:0] a, b, off;
      logic [3:0] op;
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; op = 4'($urandom);
         l = $urandom_range(1, 3); s = $urandom_range(0, 2);
         case ($urandom_range(0, 4))
            0: off = 32'd0;
            1: off = 32'd12;
            2: off = 32'd16;
            3: off = 32'd8;
            default: off = 32'd20;
         endcase
         ack_lat = l; stall_addr = BASE + off; stall_left = s;
         exp_dt = 5 * (1 + l) + SETTLE + s;
         do_run(a, b, op, 0, 0, dt);
         build_exp(a, b, op);
         checks++; if (dt !== exp_dt) begin errors++; $display("FAIL rand%0d_time got %0d want %0d", i, dt, exp_dt); end
         checks++; if (o_result !== alu(a, b, op)) begin errors++; $display("FAIL rand%0d_result got %h want %h", i, o_result, alu(a, b, op)); end
         checks++; if (!log_matches()) begin errors++; $display("FAIL rand%0d_bus_log got %0d entries want 5 matching", i, log_q.size()); end
         checks++;
         if (run_cyc_gap != 0 || run_stall_bad != 0 || o_error !== 1'b0) begin
            errors++; $display("FAIL rand%0d_protocol got gaps %0d stallbad %0d err %b want 0 0 0", i, run_cyc_gap, run_stall_bad, o_error);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_repulse();
      test_back_to_back();
`ifdef WB_MASTER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
